mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-port round-robin arbiter that shares one downstream generic bus between the core's instruction-fetch bus and data bus. It sits between the no-memory core top and a single-ported memory or bus bridge. It serialises fetch and load/store transactions, guarantees that neither requester starves, and adds a downstream-hang watchdog.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024. Maximum number of cycles a granted transaction may hold the downstream bus busy; 0 disables the watchdog.
- TIMEOUT_RDATA, 32'hBAD1_BAD1. Read data returned to the owner when a transaction is aborted.

Ports:
- CLK  in  1  Single clock; all state updates on the rising edge.
- RST  in  1  Reset. Synchronous and active-high.
- igen_bus_if  generic_bus_if.generic_bus  Instruction requester. Signals used: addr[31:0], wdata[31:0], rdata[31:0], ren, wen, byte_en[3:0], busy.
- dgen_bus_if  generic_bus_if.generic_bus  Data requester. Same signal set.
- mgen_bus_if  generic_bus_if.cpu  Downstream shared bus.
- timeout  out  1  One-cycle pulse when the watchdog aborts a transaction.
- owner  out  2  Current grant: 2'b00 none, 2'b01 instruction, 2'b10 data.

## Operation
- Generic bus semantics:
  - A requester asserts ren or wen and holds addr, wdata and byte_en stable until it samples busy=0.
  - busy=0 means the transfer completes in that cycle, and rdata is valid in that cycle.
- FSM states: IDLE, GNT_I, GNT_D.
- IDLE:
  - Downstream ren, wen and byte_en are 0; addr and wdata are 0.
  - Both requester busy outputs are 1.
  - A requester is pending when it has ren|wen asserted.
- Arbitration (evaluated in IDLE only):
  - If only I is pending, next state is GNT_I. If only D is pending, next state is GNT_D. If neither is pending, stay in IDLE.
  - If both are pending, grant the requester that was not granted last (last_grant register).
  - last_grant updates when a grant is issued.
- GNT_x state:
  - Downstream addr, wdata, ren, wen and byte_en follow the owner's live signals combinationally.
  - Owner busy = mgen busy. Non-owner busy = 1.
  - Both requesters' rdata = mgen rdata.
- Completion: in GNT_x with mgen busy=0, the transfer completes and the next state is IDLE. IDLE always lasts one cycle after a grant, so a requester's stale request in its completion cycle cannot be re-granted.
- Owner drops its request while granted (protocol violation): treat as completion and return to IDLE; downstream sees ren=wen=0.
- Watchdog:
  - A counter clears on entry to GNT_x and increments each GNT_x cycle in which mgen busy=1.
  - When TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 with busy still 1, the abort fires that cycle:
    - owner busy is forced to 0;
    - owner rdata = TIMEOUT_RDATA;
    - downstream ren and wen are forced to 0;
    - timeout=1;
    - next state is IDLE.
  - The counter saturates, is at least 16 bits wide, and is 0 in IDLE.
- owner output equals the registered state encoding.

## Timing
- Reset values:
  - state = IDLE, last_grant = I (so the first tie goes to D).
  - Watchdog counter = 0, timeout = 0, owner = 2'b00.
  - Both requester busy = 1.
  - Downstream ren = wen = 0, byte_en = 0.
- Reset mid-transaction aborts the grant with no response to the owner. The downstream side sees ren/wen drop in the cycle after the RST edge.
- Latency:
  - Request seen in IDLE at cycle N → grant at cycle N+1, when the downstream request is first asserted.
  - With a zero-wait memory, requester busy=0 at N+1.
  - Minimum occupancy is 2 cycles per transaction, including the IDLE gap.
- Back-to-back requests from both sides alternate I, D, I, D…, each transaction separated by one IDLE cycle.
- A request arriving in the same cycle as another requester's completion waits for the IDLE cycle.
- timeout is high for exactly one cycle. The owner sees busy=0 in that same cycle.

## Test plan
- Single fetch, zero-wait memory:
  - I ren at addr 0x8000_0000 in cycle 1 → mgen ren=1 in cycle 2 with the same addr.
  - igen busy=0 with rdata=mem[0x8000_0000] in cycle 2.
  - owner returns to 00 in cycle 3.
- Simultaneous I read and D write (addr 0x100, wdata 0xDEAD_BEEF, byte_en 4'hF) right after reset:
  - D is granted first; the write lands.
  - I is granted at the following IDLE+1 and receives correct data.
  - igen busy stays 1 throughout the D grant.
- Both requesters continuously pending for 10 transactions → grant order is strictly D, I, D, I…, with no requester waiting more than one transaction.
- Memory with 3 wait states and a D byte write (byte_en 4'b0010) → dgen busy=1 for 3 cycles, then 0. Only byte 1 of the word is changed.
- TIMEOUT_CYCLES=8 with downstream busy stuck at 1 under an I read → after 8 grant cycles:
  - timeout pulses;
  - igen busy=0 with rdata=0xBAD1_BAD1;
  - mgen ren drops;
  - a pending D request is served next.
- RST asserted on the 2nd wait cycle of a D read → the next cycle shows owner=00 and mgen ren=0. After RST is released, a new I request is served normally.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Generic bus bundle shared by the core's fetch/data ports and the memory side.
// The generic_bus modport is the responder view: it sees a request and answers
// with busy/rdata. The cpu modport is the initiator view that drives a request.
interface generic_bus_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ren;
    logic        wen;
    logic [3:0]  byte_en;
    logic        busy;

    modport generic_bus (
        input  addr,
        input  wdata,
        input  ren,
        input  wen,
        input  byte_en,
        output rdata,
        output busy
    );

    modport cpu (
        output addr,
        output wdata,
        output ren,
        output wen,
        output byte_en,
        input  rdata,
        input  busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter between instruction fetch and data buses onto
// one downstream generic bus, with a watchdog that aborts hung transfers.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hBAD1_BAD1
) (
    input  logic                   CLK,
    input  logic                   RST,
    generic_bus_if.generic_bus     igen_bus_if,
    generic_bus_if.generic_bus     dgen_bus_if,
    generic_bus_if.cpu             mgen_bus_if,
    output logic                   timeout,
    output logic [1:0]             owner
);

    // Watchdog counter is at least 16 bits, wider if TIMEOUT_CYCLES needs it.
    localparam int unsigned TW_MIN = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TW     = (TW_MIN > 16) ? TW_MIN : 16;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic          TO_EN   = (TIMEOUT_CYCLES != 0);

    // State encoding doubles as the owner output.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_d;      // 1: last grant went to D, 0: to I
    logic          last_d_nxt;
    logic [TW-1:0] wd_cnt;
    logic [TW-1:0] wd_cnt_nxt;

    logic          i_pend;
    logic          d_pend;
    logic          granted;
    logic          sel_d;
    logic          own_pend;
    logic          own_busy;
    logic [31:0]   own_rdata;
    logic          wd_hit;

    // Request detection and owner selection.
    always_comb begin
        i_pend   = igen_bus_if.ren | igen_bus_if.wen;
        d_pend   = dgen_bus_if.ren | dgen_bus_if.wen;
        granted  = (state != IDLE);
        sel_d    = (state == GNT_D);
        own_pend = sel_d ? d_pend : i_pend;
        wd_hit   = TO_EN && (wd_cnt == TO_LAST);
    end

    // Next-state, arbitration, watchdog and downstream/requester muxing.
    always_comb begin
        state_nxt   = state;
        last_d_nxt  = last_d;
        wd_cnt_nxt  = '0;
        timeout     = 1'b0;
        own_busy    = 1'b1;
        own_rdata   = mgen_bus_if.rdata;

        mgen_bus_if.addr    = '0;
        mgen_bus_if.wdata   = '0;
        mgen_bus_if.ren     = 1'b0;
        mgen_bus_if.wen     = 1'b0;
        mgen_bus_if.byte_en = '0;

        unique case (state)
            IDLE: begin
                if (i_pend && d_pend) begin
                    if (last_d) begin
                        state_nxt  = GNT_I;
                        last_d_nxt = 1'b0;
                    end else begin
                        state_nxt  = GNT_D;
                        last_d_nxt = 1'b1;
                    end
                end else if (i_pend) begin
                    state_nxt  = GNT_I;
                    last_d_nxt = 1'b0;
                end else if (d_pend) begin
                    state_nxt  = GNT_D;
                    last_d_nxt = 1'b1;
                end
            end

            GNT_I, GNT_D: begin
                // Downstream follows the owner's live request signals.
                if (sel_d) begin
                    mgen_bus_if.addr    = dgen_bus_if.addr;
                    mgen_bus_if.wdata   = dgen_bus_if.wdata;
                    mgen_bus_if.ren     = dgen_bus_if.ren;
                    mgen_bus_if.wen     = dgen_bus_if.wen;
                    mgen_bus_if.byte_en = dgen_bus_if.byte_en;
                end else begin
                    mgen_bus_if.addr    = igen_bus_if.addr;
                    mgen_bus_if.wdata   = igen_bus_if.wdata;
                    mgen_bus_if.ren     = igen_bus_if.ren;
                    mgen_bus_if.wen     = igen_bus_if.wen;
                    mgen_bus_if.byte_en = igen_bus_if.byte_en;
                end
                own_busy = mgen_bus_if.busy;

                if (!own_pend || !mgen_bus_if.busy) begin
                    // Normal completion, or the owner withdrew its request.
                    state_nxt = IDLE;
                end else if (wd_hit) begin
                    // Abort: release the owner with poison data, retract downstream.
                    state_nxt       = IDLE;
                    timeout         = 1'b1;
                    own_busy        = 1'b0;
                    own_rdata       = TIMEOUT_RDATA;
                    mgen_bus_if.ren = 1'b0;
                    mgen_bus_if.wen = 1'b0;
                end else begin
                    wd_cnt_nxt = (wd_cnt == '1) ? wd_cnt : wd_cnt + TW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        igen_bus_if.busy  = 1'b1;
        dgen_bus_if.busy  = 1'b1;
        igen_bus_if.rdata = mgen_bus_if.rdata;
        dgen_bus_if.rdata = mgen_bus_if.rdata;
        if (state == GNT_I) begin
            igen_bus_if.busy  = own_busy;
            igen_bus_if.rdata = own_rdata;
        end
        if (state == GNT_D) begin
            dgen_bus_if.busy  = own_busy;
            dgen_bus_if.rdata = own_rdata;
        end
    end

    // State, round-robin history and watchdog registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            last_d <= 1'b0;
            wd_cnt <= '0;
        end else begin
            state  <= state_nxt;
            last_d <= last_d_nxt;
            wd_cnt <= granted ? wd_cnt_nxt : '0;
        end
    end

    assign owner = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small wait-state memory model.
module tb_mem_bus_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       timeout;
    logic [1:0] owner;

    generic_bus_if igen ();
    generic_bus_if dgen ();
    generic_bus_if mgen ();

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_RDATA  (32'hBAD1_BAD1)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .igen_bus_if (igen),
        .dgen_bus_if (dgen),
        .mgen_bus_if (mgen),
        .timeout     (timeout),
        .owner       (owner)
    );

    // Memory model: word-indexed, initial content 0x1000_0000 + index.
    logic [31:0] mem [0:255];
    int unsigned wait_states = 0;
    bit          stuck       = 1'b0;
    int unsigned wcnt;
    logic        mreq;

    always_comb begin
        mreq       = mgen.ren | mgen.wen;
        mgen.busy  = mreq ? (stuck || (wcnt < wait_states)) : 1'b1;
        mgen.rdata = mem[mgen.addr[9:2]];
    end

    always @(posedge CLK) begin
        if (RST) begin
            wcnt <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else begin
            if (mreq && mgen.busy) wcnt <= wcnt + 1;
            else                   wcnt <= 0;
            if (mreq && !mgen.busy && mgen.wen) begin
                for (int b = 0; b < 4; b++)
                    if (mgen.byte_en[b])
                        mem[mgen.addr[9:2]][8*b +: 8] <= mgen.wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic i_req(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        igen.ren = r; igen.wen = w; igen.addr = a; igen.wdata = d; igen.byte_en = be;
    endtask

    task automatic d_req(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        dgen.ren = r; dgen.wen = w; dgen.addr = a; dgen.wdata = d; dgen.byte_en = be;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_sim time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [1:0] exp_own;
        RST = 1'b1;
        i_req(0, 0, '0, '0, '0);
        d_req(0, 0, '0, '0, '0);
        next_cycle();
        next_cycle();
        RST = 1'b0;

        // Reset state
        sample();
        check("rst_owner",   32'(owner),        32'd0);
        check("rst_ibusy",   32'(igen.busy),    32'd1);
        check("rst_dbusy",   32'(dgen.busy),    32'd1);
        check("rst_mren",    32'(mgen.ren),     32'd0);
        check("rst_mwen",    32'(mgen.wen),     32'd0);
        check("rst_mbe",     32'(mgen.byte_en), 32'd0);
        check("rst_timeout", 32'(timeout),      32'd0);

        // Single zero-wait fetch
        next_cycle();
        i_req(1, 0, 32'h8000_0000, '0, 4'hF);
        sample();
        check("f1_owner_c1", 32'(owner),    32'd0);
        check("f1_mren_c1",  32'(mgen.ren), 32'd0);
        next_cycle();
        sample();
        check("f1_owner_c2", 32'(owner),      32'd1);
        check("f1_mren_c2",  32'(mgen.ren),   32'd1);
        check("f1_maddr",    mgen.addr,       32'h8000_0000);
        check("f1_ibusy",    32'(igen.busy),  32'd0);
        check("f1_irdata",   igen.rdata,      32'h1000_0000);
        next_cycle();
        i_req(0, 0, '0, '0, '0);
        sample();
        check("f1_owner_c3", 32'(owner),    32'd0);
        check("f1_mren_c3",  32'(mgen.ren), 32'd0);

        // Simultaneous I read / D write right after reset: D wins the tie
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
        i_req(1, 0, 32'h8000_0004, '0, 4'hF);
        d_req(0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
        sample();
        check("tie_owner_c1", 32'(owner), 32'd0);
        next_cycle();
        sample();
        check("tie_owner_c2", 32'(owner),        32'd2);
        check("tie_mwen",     32'(mgen.wen),     32'd1);
        check("tie_mren",     32'(mgen.ren),     32'd0);
        check("tie_maddr",    mgen.addr,         32'h0000_0100);
        check("tie_mwdata",   mgen.wdata,        32'hDEAD_BEEF);
        check("tie_mbe",      32'(mgen.byte_en), 32'hF);
        check("tie_dbusy",    32'(dgen.busy),    32'd0);
        check("tie_ibusy_c2", 32'(igen.busy),    32'd1);
        next_cycle();
        d_req(0, 0, '0, '0, '0);
        sample();
        check("tie_owner_c3", 32'(owner),     32'd0);
        check("tie_ibusy_c3", 32'(igen.busy), 32'd1);
        next_cycle();
        sample();
        check("tie_owner_c4", 32'(owner),     32'd1);
        check("tie_ibusy_c4", 32'(igen.busy), 32'd0);
        check("tie_irdata",   igen.rdata,     32'h1000_0001);
        check("tie_memwr",    mem[64],        32'hDEAD_BEEF);

        // Both continuously pending: IDLE, D, IDLE, I, ...
        next_cycle();
        i_req(1, 0, 32'h8000_0008, '0, 4'hF);
        d_req(1, 0, 32'h8000_000C, '0, 4'hF);
        for (int c = 0; c < 20; c++) begin
            if (c > 0) next_cycle();
            sample();
            exp_own = (c % 2 == 0) ? 2'd0 : (((c / 2) % 2 == 0) ? 2'd2 : 2'd1);
            check($sformatf("rr_owner_%0d", c), 32'(owner), 32'(exp_own));
            if (exp_own == 2'd1) check($sformatf("rr_dbusy_%0d", c), 32'(dgen.busy), 32'd1);
            if (exp_own == 2'd2) check($sformatf("rr_ibusy_%0d", c), 32'(igen.busy), 32'd1);
        end
        next_cycle();
        i_req(0, 0, '0, '0, '0);
        d_req(0, 0, '0, '0, '0);
        sample();
        check("rr_owner_end", 32'(owner), 32'd0);

        // 3 wait states, D byte write to byte 1 only
        wait_states = 3;
        next_cycle();
        d_req(0, 1, 32'h0000_0100, 32'h1122_3344, 4'b0010);
        sample();
        check("ws_owner_c1", 32'(owner), 32'd0);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            sample();
            check($sformatf("ws_dbusy_w%0d", k), 32'(dgen.busy), 32'd1);
        end
        check("ws_owner_w", 32'(owner), 32'd2);
        next_cycle();
        sample();
        check("ws_dbusy_done", 32'(dgen.busy), 32'd0);
        next_cycle();
        d_req(0, 0, '0, '0, '0);
        sample();
        check("ws_owner_end", 32'(owner), 32'd0);
        check("ws_memwr",     mem[64],    32'hDEAD_33EF);
        wait_states = 0;

        // Watchdog: stuck downstream under I read, D pending behind it
        stuck = 1'b1;
        next_cycle();
        i_req(1, 0, 32'h8000_0000, '0, 4'hF);
        d_req(1, 0, 32'h8000_0008, '0, 4'hF);
        sample();
        check("wd_owner_c1", 32'(owner), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            sample();
            check($sformatf("wd_owner_g%0d", k), 32'(owner), 32'd1);
            if (k < 8) begin
                check($sformatf("wd_timeout_g%0d", k), 32'(timeout),   32'd0);
                check($sformatf("wd_ibusy_g%0d", k),   32'(igen.busy), 32'd1);
            end else begin
                check("wd_timeout_fire", 32'(timeout),   32'd1);
                check("wd_ibusy_fire",   32'(igen.busy), 32'd0);
                check("wd_irdata_fire",  igen.rdata,     32'hBAD1_BAD1);
                check("wd_mren_fire",    32'(mgen.ren),  32'd0);
                check("wd_dbusy_fire",   32'(dgen.busy), 32'd1);
            end
        end
        next_cycle();
        i_req(0, 0, '0, '0, '0);
        stuck = 1'b0;
        sample();
        check("wd_owner_idle",   32'(owner),   32'd0);
        check("wd_timeout_idle", 32'(timeout), 32'd0);
        next_cycle();
        sample();
        check("wd_owner_d",  32'(owner),     32'd2);
        check("wd_dbusy_d",  32'(dgen.busy), 32'd0);
        check("wd_drdata_d", dgen.rdata,     32'h1000_0002);
        next_cycle();
        d_req(0, 0, '0, '0, '0);
        wait_states = 3;
        sample();
        check("rs_owner_pre", 32'(owner), 32'd0);

        // Reset on second wait cycle of a D read, then a normal I fetch
        next_cycle();
        d_req(1, 0, 32'h8000_000C, '0, 4'hF);
        next_cycle();
        sample();
        check("rs_owner_w1", 32'(owner),     32'd2);
        check("rs_dbusy_w1", 32'(dgen.busy), 32'd1);
        next_cycle();
        RST = 1'b1;
        sample();
        check("rs_mren_w2", 32'(mgen.ren), 32'd1);
        next_cycle();
        RST = 1'b0;
        d_req(0, 0, '0, '0, '0);
        wait_states = 0;
        sample();
        check("rs_owner_after", 32'(owner),     32'd0);
        check("rs_mren_after",  32'(mgen.ren),  32'd0);
        check("rs_dbusy_after", 32'(dgen.busy), 32'd1);
        next_cycle();
        i_req(1, 0, 32'h8000_0010, '0, 4'hF);
        sample();
        check("rs_owner_c1", 32'(owner), 32'd0);
        next_cycle();
        sample();
        check("rs_owner_i",  32'(owner),     32'd1);
        check("rs_ibusy_i",  32'(igen.busy), 32'd0);
        check("rs_irdata_i", igen.rdata,     32'h1000_0004);
        next_cycle();
        i_req(0, 0, '0, '0, '0);
        sample();
        check("rs_owner_end", 32'(owner), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
